// File: rtl/text_pkg.sv
// text_pkg: shared definitions for the VGA alarm-clock text overlay.
//   - display mode encoding (2-bit state of the mode FSM)
//   - colour width and default colour constants
//   - small helpers for the mode sequence
package text_pkg;

    localparam int COLOR_W = 12;

    localparam logic [1:0] MODE_TIME_VIEW  = 2'd0;
    localparam logic [1:0] MODE_ALARM_VIEW = 2'd1;
    localparam logic [1:0] MODE_SET_TIME   = 2'd2;
    localparam logic [1:0] MODE_SET_ALARM  = 2'd3;

    localparam logic [COLOR_W-1:0] DEF_COLOR_BG    = 12'h000;
    localparam logic [COLOR_W-1:0] DEF_COLOR_TEXT  = 12'hFFF;
    localparam logic [COLOR_W-1:0] DEF_COLOR_DIGIT = 12'h0F0;
    localparam logic [COLOR_W-1:0] DEF_COLOR_ALARM = 12'hF00;

    // TIME_VIEW -> ALARM_VIEW -> SET_TIME -> SET_ALARM -> TIME_VIEW
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        logic [1:0] n;
        case (m)
            MODE_TIME_VIEW:  n = MODE_ALARM_VIEW;
            MODE_ALARM_VIEW: n = MODE_SET_TIME;
            MODE_SET_TIME:   n = MODE_SET_ALARM;
            default:         n = MODE_TIME_VIEW;
        endcase
        return n;
    endfunction

    function automatic logic is_set_mode(input logic [1:0] m);
        return (m == MODE_SET_TIME) || (m == MODE_SET_ALARM);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// blink_timer: frame-counting blink phase generator.
// Ports:
//   clk, reset      clock, async active-high reset
//   i_frame_start   one-cycle frame strobe; advances the frame count
//   i_restart       forces count=0, phase=1 (wins over i_frame_start)
//   o_blink_ph      blink phase, 1 = on half-period
// Only built when TEXT_BLINK_EN is defined.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic i_frame_start,
    input  logic i_restart,
    output logic o_blink_ph
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic [CW-1:0] r_blink_cnt;
    logic          r_blink_ph;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
        end else if (i_restart) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
        end else if (i_frame_start) begin
            if (r_blink_cnt == LAST) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign o_blink_ph = r_blink_ph;

endmodule

// File: rtl/text_layer_sched.sv
// text_layer_sched: frame-synchronous controller for the text overlay.
// Owns the display-mode FSM, the frame-sampled alarm ON/OFF select and
// the blink timer, and merges the glyph strobes into a registered pixel.
// Optional feature macro: TEXT_BLINK_EN (blink counter, SET-mode digit
// blanking and alarm flash); when undefined the blink phase is held at 1.
// Ports:
//   clk, reset       clock, async active-high reset
//   p_tick           pixel-rate strobe; rgb and frame logic advance only on it
//   video_on         visible-area flag
//   pixel_x/pixel_y  current pixel coordinate (10 bits each)
//   mode_btn         single-cycle press, latched even without p_tick
//   alarm_en         alarm armed status, sampled at frame start
//   alarm_ring       alarm ringing level
//   time_text_on, alarm_text_on, digit_on   glyph "on" strobes
//   mode             current mode (FSM state)
//   alarm_text_en    frame-stable copy of alarm_en
//   frame_start      p_tick at pixel (0,0), combinational
//   rgb              registered 12-bit pixel colour
// Handshake: p_tick is a qualifier, not a valid/ready pair; the pixel
// presented with p_tick=1 appears on rgb after that edge and holds until
// the next p_tick.
module text_layer_sched
    import text_pkg::*;
#(
    parameter int                 BLINK_FRAMES = 30,
    parameter logic [COLOR_W-1:0] COLOR_BG     = DEF_COLOR_BG,
    parameter logic [COLOR_W-1:0] COLOR_TEXT   = DEF_COLOR_TEXT,
    parameter logic [COLOR_W-1:0] COLOR_DIGIT  = DEF_COLOR_DIGIT,
    parameter logic [COLOR_W-1:0] COLOR_ALARM  = DEF_COLOR_ALARM
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p_tick,
    input  logic               video_on,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               mode_btn,
    input  logic               alarm_en,
    input  logic               alarm_ring,
    input  logic               time_text_on,
    input  logic               alarm_text_on,
    input  logic               digit_on,
    output logic [1:0]         mode,
    output logic               alarm_text_en,
    output logic               frame_start,
    output logic [COLOR_W-1:0] rgb
);

    if (BLINK_FRAMES < 2) begin : g_bad_blink_frames
        $error("BLINK_FRAMES must be at least 2");
    end

    logic [1:0]         r_mode;
    logic               r_pending;
    logic               r_alarm_text_en;
    logic [COLOR_W-1:0] r_rgb;
    logic               w_frame_start;
    logic               w_mode_adv;
    logic               w_blink_ph;
    logic               w_digit;
    logic               w_time_lbl;
    logic               w_alarm_lbl;
    logic [COLOR_W-1:0] w_pixel;

    assign w_frame_start = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

    // A press on the frame_start cycle itself counts as already pending.
    assign w_mode_adv = w_frame_start && (r_pending || mode_btn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode          <= MODE_TIME_VIEW;
            r_pending       <= 1'b0;
            r_alarm_text_en <= 1'b0;
        end else if (w_frame_start) begin
            r_alarm_text_en <= alarm_en;
            r_pending       <= 1'b0;
            if (w_mode_adv) begin
                r_mode <= next_mode(r_mode);
            end
        end else if (mode_btn) begin
            r_pending <= 1'b1;
        end
    end

`ifdef TEXT_BLINK_EN
    logic r_ring_d;
    logic w_restart;

    // Ring edge is tracked every clock so it is seen even between p_ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ring_d <= 1'b0;
        end else begin
            r_ring_d <= alarm_ring;
        end
    end

    assign w_restart = w_mode_adv || (alarm_ring && !r_ring_d);

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk           (clk),
        .reset         (reset),
        .i_frame_start (w_frame_start),
        .i_restart     (w_restart),
        .o_blink_ph    (w_blink_ph)
    );
`else
    assign w_blink_ph = 1'b1;
`endif

    assign w_time_lbl  = time_text_on &&
                         ((r_mode == MODE_TIME_VIEW) || (r_mode == MODE_SET_TIME));
    assign w_alarm_lbl = alarm_text_on &&
                         ((r_mode == MODE_ALARM_VIEW) || (r_mode == MODE_SET_ALARM));
    // Digits blank during the off phase only while editing.
    assign w_digit     = digit_on && !(is_set_mode(r_mode) && !w_blink_ph);

    always_comb begin
        w_pixel = COLOR_BG;
        if (!video_on) begin
            w_pixel = '0;
        end else if (w_digit) begin
            w_pixel = (alarm_ring && w_blink_ph) ? COLOR_ALARM : COLOR_DIGIT;
        end else if (w_time_lbl || w_alarm_lbl) begin
            w_pixel = COLOR_TEXT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
        end else if (p_tick) begin
            r_rgb <= w_pixel;
        end
    end

    assign mode          = r_mode;
    assign alarm_text_en = r_alarm_text_en;
    assign frame_start   = w_frame_start;
    assign rgb           = r_rgb;

endmodule

// File: tb/tb_text_layer_sched.sv
// Self-checking bench for text_layer_sched. The bench acts as the sync
// generator: each tick() presents one pixel with p_tick for one clock and
// idles one clock. Expected pixels go into exp_q; the monitor pops one per
// p_tick and also checks that rgb holds between ticks.
module tb_text_layer_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        mode_btn;
    logic        alarm_en;
    logic        alarm_ring;
    logic        time_text_on;
    logic        alarm_text_on;
    logic        digit_on;
    logic [1:0]  mode;
    logic        alarm_text_en;
    logic        frame_start;
    logic [11:0] rgb;

    logic [11:0] exp_q[$];
    logic [11:0] last_exp = 12'h000;
    logic        tick_prev = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    text_layer_sched #(
        .BLINK_FRAMES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .p_tick        (p_tick),
        .video_on      (video_on),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .mode_btn      (mode_btn),
        .alarm_en      (alarm_en),
        .alarm_ring    (alarm_ring),
        .time_text_on  (time_text_on),
        .alarm_text_on (alarm_text_on),
        .digit_on      (digit_on),
        .mode          (mode),
        .alarm_text_en (alarm_text_en),
        .frame_start   (frame_start),
        .rgb           (rgb)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- checker helpers ----------------
    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) tick_prev = p_tick && !reset;

    always @(negedge clk) begin
        if (reset) begin
            last_exp = 12'h000;
        end else if (tick_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rgb_unexpected: got %h with empty queue", rgb);
            end else begin
                last_exp = exp_q.pop_front();
                chk("rgb", rgb, last_exp);
            end
        end else begin
            chk("rgb_hold", rgb, last_exp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic [9:0] x, input logic [9:0] y,
                        input logic vid, input logic tt, input logic at,
                        input logic dg, input logic btn, input logic [11:0] exp);
        pixel_x       = x;
        pixel_y       = y;
        video_on      = vid;
        time_text_on  = tt;
        alarm_text_on = at;
        digit_on      = dg;
        mode_btn      = btn;
        p_tick        = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        p_tick        = 1'b0;
        mode_btn      = 1'b0;
        time_text_on  = 1'b0;
        alarm_text_on = 1'b0;
        digit_on      = 1'b0;
        pixel_x       = 10'd1;
        @(negedge clk);
    endtask

    task automatic press();
        mode_btn = 1'b1;
        @(negedge clk);
        mode_btn = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; p_tick = 1'b1; video_on = 1'b1;
        pixel_x = 10'd0; pixel_y = 10'd0; mode_btn = 1'b1;
        alarm_en = 1'b0; alarm_ring = 1'b0;
        time_text_on = 1'b0; alarm_text_on = 1'b0; digit_on = 1'b0;

        // reset held with mode_btn high for 3 cycles
        repeat (3) @(negedge clk);
        chk("reset_mode", {10'd0, mode}, 12'd0);
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_alarm_text_en", {11'd0, alarm_text_en}, 12'd0);
        chk("frame_start_at_origin", {11'd0, frame_start}, 12'd1);
        pixel_x = 10'd1;
        #1;
        chk("frame_start_off_origin", {11'd0, frame_start}, 12'd0);
        p_tick = 1'b0; mode_btn = 1'b0; reset = 1'b0;
        @(negedge clk);
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("no_press_survives_reset", {10'd0, mode}, 12'd0);

        // two presses in one frame -> single advance at next frame_start
        tick(10'd100, 10'd200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF);
        chk("mode_pending_1", {10'd0, mode}, 12'd0);
        tick(10'd300, 10'd200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
        chk("mode_pending_2", {10'd0, mode}, 12'd0);
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("mode_adv_once", {10'd0, mode}, 12'd1);
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("mode_no_second_adv", {10'd0, mode}, 12'd1);

        // alarm_en toggled mid-frame
        alarm_en = 1'b1;
        tick(10'd5, 10'd240, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("alarm_text_en_midframe", {11'd0, alarm_text_en}, 12'd0);
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("alarm_text_en_loaded", {11'd0, alarm_text_en}, 12'd1);
        alarm_en = 1'b0;
        tick(10'd7, 10'd240, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("alarm_text_en_held", {11'd0, alarm_text_en}, 12'd1);
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("alarm_text_en_cleared", {11'd0, alarm_text_en}, 12'd0);

        // ALARM_VIEW layer masking
        tick(10'd50, 10'd50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);
        tick(10'd51, 10'd50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        tick(10'd52, 10'd50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0);
        tick(10'd53, 10'd50, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h0F0);

        // press coinciding with frame_start -> SET_TIME
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        chk("mode_set_time", {10'd0, mode}, 12'd2);
        tick(10'd60, 10'd60, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0);
        tick(10'd61, 10'd60, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF);
        tick(10'd62, 10'd60, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        alarm_ring = 1'b1;
        tick(10'd63, 10'd60, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'hF00);
        tick(10'd64, 10'd60, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF);
        tick(10'd65, 10'd60, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
        alarm_ring = 1'b0;

        // SET_ALARM, then wrap to TIME_VIEW
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        chk("mode_set_alarm", {10'd0, mode}, 12'd3);
        tick(10'd70, 10'd70, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);
        tick(10'd71, 10'd70, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        chk("mode_wrap", {10'd0, mode}, 12'd0);
        tick(10'd80, 10'd80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0F0);
        tick(10'd81, 10'd80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);

        // reset mid-frame discards a pending press
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        chk("mode_before_reset", {10'd0, mode}, 12'd1);
        alarm_en = 1'b1;
        tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h0F0);
        press();
        do_reset();
        chk("midreset_mode", {10'd0, mode}, 12'd0);
        chk("midreset_rgb", rgb, 12'h000);
        chk("midreset_alarm_text_en", {11'd0, alarm_text_en}, 12'd0);
        alarm_en = 1'b0;
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("pending_discarded", {10'd0, mode}, 12'd0);

`ifdef TEXT_BLINK_EN
        // SET_TIME blink with BLINK_FRAMES=4
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        chk("blink_mode_set_time", {10'd0, mode}, 12'd2);
        for (int f = 0; f < 6; f++) begin
            tick(10'd10, 10'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (f < 4) ? 12'h0F0 : 12'h000);
            if (f < 5) tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        end
        alarm_ring = 1'b1;
        @(negedge clk);
        tick(10'd11, 10'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'hF00);
        alarm_ring = 1'b0;
`endif

        // drain scoreboard
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d pixels still expected, required 0", exp_q.size());
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
